// File: rtl/wishbone_master_if.sv
// Request/response port plus Wishbone classic bus of the wishbone_master bridge.
// The master modport is the bridge's view; slave is the CPU-side and target-side peer.
interface wishbone_master_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] req_addr_i;
  logic        req_we_i;
  logic [3:0]  req_sel_i;
  logic [31:0] req_wdata_i;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        cyc_o;
  logic        stb_o;
  logic [31:0] adr_o;
  logic [3:0]  sel_o;
  logic [31:0] dat_o;
  logic        we_o;
  logic [31:0] dat_i;
  logic        ack_i;
  logic        err_i;
  logic        rty_i;

  modport master (
    input  req_valid_i, req_addr_i, req_we_i, req_sel_i, req_wdata_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    output cyc_o, stb_o, adr_o, sel_o, dat_o, we_o,
    input  dat_i, ack_i, err_i, rty_i
  );

  modport slave (
    output req_valid_i, req_addr_i, req_we_i, req_sel_i, req_wdata_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    input  cyc_o, stb_o, adr_o, sel_o, dat_o, we_o,
    output dat_i, ack_i, err_i, rty_i
  );
endinterface

// File: rtl/wishbone_master.sv
// Wishbone classic initiator: little-endian valid/ready request port onto a big-endian
// bus, one transaction in flight, bounded rty retries and a no-response timeout.
module wishbone_master #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int MAX_RETRIES    = 3,
  parameter int RETRY_BACKOFF  = 2
) (
  input logic               clk_i,
  input logic               rst_ni,
  wishbone_master_if.master bus
);
  localparam int NUM_LANES = 4;
  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  localparam int BW = (RETRY_BACKOFF > 1) ? $clog2(RETRY_BACKOFF) : 1;
  localparam bit            TO_EN   = (TIMEOUT_CYCLES > 0);
  localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [RW-1:0] RET_MAX = RW'(MAX_RETRIES);
  localparam logic [BW-1:0] BO_LAST = BW'((RETRY_BACKOFF > 0) ? RETRY_BACKOFF - 1 : 0);

  typedef enum logic [1:0] {IDLE, BUS, BACKOFF} state_e;

  state_e                        state;
  logic [TW-1:0]                 tcnt;
  logic [RW-1:0]                 retries;
  logic [BW-1:0]                 bcnt;
  logic [NUM_LANES-1:0][7:0]     wdata_sw;
  logic [NUM_LANES-1:0][7:0]     rdata_sw;
  logic [NUM_LANES-1:0]          sel_sw;

  // Endianness swap: byte lane l on one side is lane NUM_LANES-1-l on the other.
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    assign wdata_sw[l] = bus.req_wdata_i[8*(NUM_LANES-1-l) +: 8];
    assign rdata_sw[l] = bus.dat_i[8*(NUM_LANES-1-l) +: 8];
    assign sel_sw[l]   = bus.req_sel_i[NUM_LANES-1-l];
  end

  assign bus.req_ready_o = (state == IDLE);
  assign bus.stb_o       = bus.cyc_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state           <= IDLE;
      tcnt            <= '0;
      retries         <= '0;
      bcnt            <= '0;
      bus.cyc_o       <= 1'b0;
      bus.we_o        <= 1'b0;
      bus.adr_o       <= '0;
      bus.sel_o       <= '0;
      bus.dat_o       <= '0;
      bus.rsp_valid_o <= 1'b0;
      bus.rsp_err_o   <= 1'b0;
      bus.rsp_rdata_o <= '0;
    end else begin
      bus.rsp_valid_o <= 1'b0;
      bus.rsp_err_o   <= 1'b0;
      bus.rsp_rdata_o <= '0;
      case (state)
        IDLE: begin
          if (bus.req_valid_i) begin
            bus.adr_o <= bus.req_addr_i;
            bus.sel_o <= sel_sw;
            bus.dat_o <= wdata_sw;
            bus.we_o  <= bus.req_we_i;
            bus.cyc_o <= 1'b1;
            retries   <= '0;
            tcnt      <= '0;
            state     <= BUS;
          end
        end
        BUS: begin
          // cyc drops on the same edge a termination is seen, so it is consumed once.
          if (bus.ack_i) begin
            bus.cyc_o       <= 1'b0;
            bus.rsp_valid_o <= 1'b1;
            bus.rsp_rdata_o <= bus.we_o ? '0 : rdata_sw;
            state           <= IDLE;
          end else if (bus.err_i) begin
            bus.cyc_o       <= 1'b0;
            bus.rsp_valid_o <= 1'b1;
            bus.rsp_err_o   <= 1'b1;
            state           <= IDLE;
          end else if (bus.rty_i) begin
            bus.cyc_o <= 1'b0;
            if (retries == RET_MAX) begin
              bus.rsp_valid_o <= 1'b1;
              bus.rsp_err_o   <= 1'b1;
              state           <= IDLE;
            end else begin
              retries <= retries + 1'b1;
              bcnt    <= '0;
              state   <= BACKOFF;
            end
          end else if (TO_EN && tcnt == TO_LAST) begin
            bus.cyc_o       <= 1'b0;
            bus.rsp_valid_o <= 1'b1;
            bus.rsp_err_o   <= 1'b1;
            state           <= IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        BACKOFF: begin
          if (bcnt == BO_LAST) begin
            bus.cyc_o <= 1'b1;
            tcnt      <= '0;
            state     <= BUS;
          end else begin
            bcnt <= bcnt + 1'b1;
          end
        end
        default: begin
          bus.cyc_o <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end
endmodule
